// File: rtl/manchester_link_pkg.sv
// Shared state type, frame field constants and bit-level helpers for the
// manchester_link frame engine.
package manchester_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    BLIND,
    LISTEN,
    REPORT
  } state_t;

  localparam logic [2:0] START_FIELD = 3'b000;
  localparam logic [1:0] END_FIELD   = 2'b00;

  // Widest frame the helpers accept; callers zero-extend and truncate.
  localparam int MAX_BITS = 64;

  // Each bit becomes two half-symbols, first half in the upper position:
  // 1 -> 01, 0 -> 10.
  function automatic logic [2*MAX_BITS-1:0] manch_encode(input logic [MAX_BITS-1:0] bits);
    logic [2*MAX_BITS-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      res[2*i +: 2] = {~bits[i], bits[i]};
    end
    return res;
  endfunction

  function automatic logic even_parity(input logic [MAX_BITS-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/link_env_detector.sv
// Windowed envelope detector: tracks peak amplitude per window and counts
// rising edges of the above-threshold decision, saturating.
module link_env_detector #(
  parameter int ADC_W      = 12,
  parameter int WIN_CYCLES = 40000,
  parameter int THR_DIV    = 20,
  parameter int CNT_W      = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             run,
  input  logic [ADC_W-1:0] adc,
  input  logic [ADC_W-1:0] mean_ref,
  output logic             det,
  output logic [CNT_W-1:0] count
);

  localparam int WIN_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;

  logic [WIN_W-1:0] win_cnt;
  logic [ADC_W-1:0] peak;
  logic [ADC_W-1:0] amp;
  logic [ADC_W-1:0] peak_next;
  logic [ADC_W:0]   thr;
  logic             win_end;
  logic             det_next;

  // Samples above mid-scale are folded back, so ~adc equals (2^ADC_W-1)-adc.
  assign amp       = adc[ADC_W-1] ? ~adc : adc;
  assign peak_next = (amp > peak) ? amp : peak;
  assign thr       = {1'b0, mean_ref} + ({1'b0, mean_ref} / (ADC_W+1)'(THR_DIV));
  assign det_next  = {1'b0, peak_next} > thr;
  assign win_end   = (win_cnt == WIN_W'(WIN_CYCLES - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      win_cnt <= '0;
      peak    <= '0;
      det     <= 1'b0;
      count   <= '0;
    end else if (clr) begin
      win_cnt <= '0;
      peak    <= '0;
      det     <= 1'b0;
      count   <= '0;
    end else if (run) begin
      if (win_end) begin
        win_cnt <= '0;
        peak    <= '0;
        det     <= det_next;
        if (det_next && !det && count != '1) begin
          count <= count + CNT_W'(1);
        end
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        peak    <= peak_next;
      end
    end
  end

endmodule

// File: rtl/manchester_link.sv
// Half-duplex link engine: sends a Manchester-coded command frame, blanks,
// then listens for the ground station's burst answer and reports the count.
module manchester_link
  import manchester_link_pkg::*;
#(
  parameter int PAYLOAD_W     = 8,
  parameter int ADC_W         = 12,
  parameter int HALF_CYCLES   = 100000,
  parameter int WIN_CYCLES    = 40000,
  parameter int BLIND_CYCLES  = 500000,
  parameter int LISTEN_CYCLES = 2500000,
  parameter int THR_DIV       = 20,
  parameter int CNT_W         = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 enable,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [1:0]           tx_type,
  input  logic [PAYLOAD_W-1:0] tx_payload,
  input  logic [ADC_W-1:0]     adc,
  input  logic [ADC_W-1:0]     mean_ref,
  output logic                 dout,
  output logic                 write,
  output logic                 read,
  output logic                 ans_valid,
  output logic [CNT_W-1:0]     ans_count
);

  localparam int N      = PAYLOAD_W + 8;
  localparam int SREG_W = 2 * N;
  localparam int SYM_W  = $clog2(SREG_W);

  state_t            state;
  logic [31:0]       cnt;
  logic [SYM_W-1:0]  sym_cnt;
  logic [SREG_W-1:0] sreg;
  logic [SREG_W-1:0] enc;
  logic [N-1:0]      frame;
  logic [CNT_W-1:0]  det_count;
  logic [CNT_W-1:0]  ans_hold;
  logic              det_unused;
  logic              det_clr;
  logic              det_run;

  assign frame = {START_FIELD, tx_type, tx_payload,
                  even_parity(MAX_BITS'({tx_type, tx_payload})), END_FIELD};
  assign enc   = SREG_W'(manch_encode(MAX_BITS'(frame)));

  assign det_clr = !enable || (state == BLIND && cnt == 32'(BLIND_CYCLES - 1));
  assign det_run = enable && (state == LISTEN);

  // During the report cycle the detector is frozen, so its count is shown
  // directly; afterwards the captured copy holds until the next report.
  assign ans_count = ans_valid ? det_count : ans_hold;

  link_env_detector #(
    .ADC_W     (ADC_W),
    .WIN_CYCLES(WIN_CYCLES),
    .THR_DIV   (THR_DIV),
    .CNT_W     (CNT_W)
  ) u_det (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (det_clr),
    .run     (det_run),
    .adc     (adc),
    .mean_ref(mean_ref),
    .det     (det_unused),
    .count   (det_count)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      sym_cnt   <= '0;
      sreg      <= '0;
      dout      <= 1'b0;
      write     <= 1'b0;
      read      <= 1'b0;
      tx_ready  <= 1'b0;
      ans_valid <= 1'b0;
      ans_hold  <= '0;
    end else begin
      ans_valid <= 1'b0;
      if (ans_valid) ans_hold <= det_count;
      if (!enable) begin
        state    <= IDLE;
        cnt      <= '0;
        sym_cnt  <= '0;
        dout     <= 1'b0;
        write    <= 1'b0;
        read     <= 1'b0;
        tx_ready <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt     <= '0;
            sym_cnt <= '0;
            if (tx_valid && tx_ready) begin
              sreg     <= enc;
              dout     <= enc[SREG_W-1];
              write    <= 1'b1;
              tx_ready <= 1'b0;
              state    <= TX;
            end else begin
              tx_ready <= 1'b1;
            end
          end
          TX: begin
            if (cnt == 32'(HALF_CYCLES - 1)) begin
              cnt <= '0;
              if (sym_cnt == SYM_W'(SREG_W - 1)) begin
                dout  <= 1'b0;
                write <= 1'b0;
                read  <= 1'b1;
                state <= BLIND;
              end else begin
                sym_cnt <= sym_cnt + SYM_W'(1);
                sreg    <= sreg << 1;
                dout    <= sreg[SREG_W-2];
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          BLIND: begin
            if (cnt == 32'(BLIND_CYCLES - 1)) begin
              cnt   <= '0;
              state <= LISTEN;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          LISTEN: begin
            if (cnt == 32'(LISTEN_CYCLES - 1)) begin
              cnt       <= '0;
              read      <= 1'b0;
              ans_valid <= 1'b1;
              state     <= REPORT;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          REPORT: begin
            tx_ready <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_manchester_link.sv
// Directed and randomized frames checked against a frame/answer model built
// from the link's rules with plain arithmetic over bit and sample arrays.
module tb_manchester_link;

  localparam int PAYLOAD_W     = 8;
  localparam int ADC_W         = 12;
  localparam int HALF_CYCLES   = 4;
  localparam int WIN_CYCLES    = 8;
  localparam int BLIND_CYCLES  = 10;
  localparam int LISTEN_CYCLES = 64;
  localparam int THR_DIV       = 20;
  localparam int CNT_W         = 2;
  localparam int N_HALF        = 2 * (PAYLOAD_W + 8);
  localparam int N_WIN         = LISTEN_CYCLES / WIN_CYCLES;

  logic                 clk = 1'b0;
  logic                 nrst = 1'b0;
  logic                 enable = 1'b0;
  logic                 tx_valid = 1'b0;
  logic [1:0]           tx_type = '0;
  logic [PAYLOAD_W-1:0] tx_payload = '0;
  logic [ADC_W-1:0]     adc = '0;
  logic [ADC_W-1:0]     mean_ref = '0;
  logic                 tx_ready;
  logic                 dout;
  logic                 write;
  logic                 read;
  logic                 ans_valid;
  logic [CNT_W-1:0]     ans_count;

  int checks = 0;
  int errors = 0;
  int exp_halfs[$];
  int samples[LISTEN_CYCLES];
  int last_count = 0;

  manchester_link #(
    .PAYLOAD_W    (PAYLOAD_W),
    .ADC_W        (ADC_W),
    .HALF_CYCLES  (HALF_CYCLES),
    .WIN_CYCLES   (WIN_CYCLES),
    .BLIND_CYCLES (BLIND_CYCLES),
    .LISTEN_CYCLES(LISTEN_CYCLES),
    .THR_DIV      (THR_DIV),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .enable    (enable),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_type   (tx_type),
    .tx_payload(tx_payload),
    .adc       (adc),
    .mean_ref  (mean_ref),
    .dout      (dout),
    .write     (write),
    .read      (read),
    .ans_valid (ans_valid),
    .ans_count (ans_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Frame bits MSB first, then two half-symbols per bit, first half first.
  function automatic void model_halfs(input logic [1:0] t, input logic [PAYLOAD_W-1:0] p);
    int bits[$];
    bits = {};
    repeat (3) bits.push_back(0);
    for (int i = 1; i >= 0; i--) bits.push_back(int'(t[i]));
    for (int i = PAYLOAD_W - 1; i >= 0; i--) bits.push_back(int'(p[i]));
    bits.push_back($countones({t, p}) % 2);
    bits.push_back(0);
    bits.push_back(0);
    exp_halfs.delete();
    foreach (bits[i]) begin
      exp_halfs.push_back(bits[i] == 1 ? 0 : 1);
      exp_halfs.push_back(bits[i]);
    end
  endfunction

  function automatic int model_count(input int mref);
    int thr;
    int cnt;
    int prev;
    thr  = mref + mref / THR_DIV;
    cnt  = 0;
    prev = 0;
    for (int w = 0; w < N_WIN; w++) begin
      int pk;
      int d;
      pk = 0;
      for (int k = 0; k < WIN_CYCLES; k++) begin
        int s;
        int a;
        s = samples[w*WIN_CYCLES + k];
        a = (s < (1 << (ADC_W-1))) ? s : ((1 << ADC_W) - 1) - s;
        if (a > pk) pk = a;
      end
      d = (pk > thr) ? 1 : 0;
      if (d == 1 && prev == 0) cnt++;
      prev = d;
    end
    return (cnt > 3) ? 3 : cnt;
  endfunction

  task automatic fill_windows(input logic [7:0] mask, input int burst, input int quiet);
    for (int c = 0; c < LISTEN_CYCLES; c++) samples[c] = mask[c / WIN_CYCLES] ? burst : quiet;
  endtask

  task automatic fill_random();
    for (int w = 0; w < N_WIN; w++) begin
      int hit;
      int pos;
      hit = int'($urandom_range(0, 1));
      pos = int'($urandom_range(0, WIN_CYCLES - 1));
      for (int k = 0; k < WIN_CYCLES; k++) begin
        int amp;
        amp = int'($urandom_range(0, 'h3FF));
        if (hit == 1 && k == pos) amp = int'($urandom_range('h434, 'h7FF));
        samples[w*WIN_CYCLES + k] = ($urandom_range(0, 1) == 1) ? 4095 - amp : amp;
      end
    end
  endtask

  task automatic start_frame(input logic [1:0] t, input logic [PAYLOAD_W-1:0] p, output bit ok);
    int waited;
    waited = 0;
    while (tx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    ok = (tx_ready === 1'b1);
    check_output("handshake_ready", tx_ready, 1);
    if (!ok) return;
    tx_type    = t;
    tx_payload = p;
    tx_valid   = 1'b1;
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [1:0] t, input logic [PAYLOAD_W-1:0] p,
                                input int mref, input int stop_after);
    bit ok;
    int exp_cnt;
    model_halfs(t, p);
    mean_ref = ADC_W'(mref);
    exp_cnt  = model_count(mref);
    start_frame(t, p, ok);
    if (!ok) return;
    for (int j = 0; j < N_HALF * HALF_CYCLES; j++) begin
      check_output("tx_dout", dout, exp_halfs[j / HALF_CYCLES]);
      check_output("tx_write", write, 1);
      check_output("tx_ready_busy", tx_ready, 0);
      tx_type    = 2'($urandom);
      tx_payload = PAYLOAD_W'($urandom);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check_output("blind_read", read, 1);
    check_output("blind_dout", dout, 0);
    check_output("blind_write", write, 0);
    repeat (BLIND_CYCLES - 1) @(negedge clk);
    for (int c = 0; c < LISTEN_CYCLES; c++) begin
      @(negedge clk);
      adc = ADC_W'(samples[c]);
      if (c == stop_after) return;
      if (c == 0) begin
        check_output("listen_read", read, 1);
        check_output("listen_ans_hold", ans_count, last_count);
      end
    end
    check_output("ans_valid_early", ans_valid, 0);
    @(negedge clk);
    check_output("ans_valid_pulse", ans_valid, 1);
    check_output("ans_count", ans_count, exp_cnt);
    check_output("report_read", read, 0);
    @(negedge clk);
    check_output("ans_valid_single", ans_valid, 0);
    check_output("ready_after_report", tx_ready, 1);
    check_output("ans_count_held", ans_count, exp_cnt);
    last_count = exp_cnt;
  endtask

  initial begin
    bit ok;
    int seen;
    $display("[TB] manchester_link bench starting");
    repeat (3) @(negedge clk);
    check_output("rst_dout", dout, 0);
    check_output("rst_write", write, 0);
    check_output("rst_read", read, 0);
    check_output("rst_tx_ready", tx_ready, 0);
    check_output("rst_ans_valid", ans_valid, 0);
    check_output("rst_ans_count", ans_count, 0);
    nrst   = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    check_output("idle_ready", tx_ready, 1);

    fill_windows(8'h00, 'h600, 'h100);
    apply_stimulus(2'b01, 8'hC9, 'h400, -1);
    fill_windows(8'h0A, 'h600, 'h100);
    apply_stimulus(2'($urandom), 8'($urandom), 'h400, -1);
    fill_windows(8'h0A, 'hA00, 'h100);
    apply_stimulus(2'($urandom), 8'($urandom), 'h400, -1);
    fill_windows(8'h55, 'h600, 'h100);
    apply_stimulus(2'($urandom), 8'($urandom), 'h400, -1);
    fill_windows(8'h06, 'h600, 'h100);
    apply_stimulus(2'($urandom), 8'($urandom), 'h400, -1);
    fill_windows(8'h80, 'h600, 'h100);
    apply_stimulus(2'($urandom), 8'($urandom), 'h400, -1);

    // Peaks exactly at threshold (either polarity) must not count; one above does.
    fill_windows(8'h00, 'h600, 'h100);
    for (int c = 16; c < 24; c++) samples[c] = 'h433;
    samples[35] = 'h434;
    samples[50] = 'hBCC;
    apply_stimulus(2'b11, 8'h00, 'h400, -1);
    fill_windows(8'hFF, 'h7FF, 'h7FF);
    apply_stimulus(2'b00, 8'hFF, 'hFFF, -1);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      apply_stimulus(2'($urandom), 8'($urandom), 'h400, -1);
    end

    model_halfs(2'b10, 8'h5A);
    start_frame(2'b10, 8'h5A, ok);
    if (ok) begin
      for (int j = 0; j < 10 * HALF_CYCLES; j++) @(negedge clk);
      check_output("abort_pre_dout", dout, exp_halfs[10]);
      enable   = 1'b0;
      tx_valid = 1'b0;
      @(negedge clk);
      check_output("abort_dout", dout, 0);
      check_output("abort_write", write, 0);
      check_output("abort_tx_ready", tx_ready, 0);
      seen = 0;
      repeat (200) begin
        @(negedge clk);
        if (ans_valid !== 1'b0 || dout !== 1'b0 || read !== 1'b0) seen = 1;
      end
      check_output("abort_quiet", seen, 0);
      check_output("abort_ans_kept", ans_count, last_count);
      enable = 1'b1;
      @(negedge clk);
      check_output("abort_ready_back", tx_ready, 1);
    end
    fill_random();
    apply_stimulus(2'($urandom), 8'($urandom), 'h400, -1);

    fill_windows(8'h0A, 'h600, 'h100);
    apply_stimulus(2'b01, 8'h3C, 'h400, -1);
    fill_random();
    apply_stimulus(2'b10, 8'hA5, 'h400, 20);
    #2;
    nrst = 1'b0;
    #1;
    check_output("arst_dout", dout, 0);
    check_output("arst_write", write, 0);
    check_output("arst_read", read, 0);
    check_output("arst_tx_ready", tx_ready, 0);
    check_output("arst_ans_valid", ans_valid, 0);
    check_output("arst_ans_count", ans_count, 0);
    @(negedge clk);
    nrst       = 1'b1;
    last_count = 0;
    fill_random();
    apply_stimulus(2'($urandom), 8'($urandom), 'h400, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    check_output("watchdog", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
